// File: rtl/mips_instr_encoder_if.sv
// Request/response bundle for mips_instr_encoder: abstract op request in, encoded MIPS word out.
// master = request producer / word consumer; slave = the encoder.
interface mips_instr_encoder_if #(
  parameter int DEPTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [3:0]                 op_sel;
  logic [4:0]                 rs;
  logic [4:0]                 rt;
  logic [4:0]                 rd;
  logic [15:0]                imm;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                instr;
  logic [5:0]                 opc;
  logic [5:0]                 funct;
  logic [$clog2(DEPTH):0]     level;
  logic                       err;

  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, out_ready,
    input  in_ready, out_valid, instr, opc, funct, level, err
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, out_ready,
    output in_ready, out_valid, instr, opc, funct, level, err
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes abstract op requests into 32-bit MIPS words and queues them in a DEPTH-entry FIFO.
// Optional macro MIPS_ENC_ILLEGAL_TRAP_EN: drop illegal op_sel and raise sticky err instead of pushing a NOP.
module mips_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_instr_encoder_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [31:0] encode(input logic [3:0]  op,
                                         input logic [4:0]  s,
                                         input logic [4:0]  t,
                                         input logic [4:0]  d,
                                         input logic [15:0] im);
    logic [31:0] w;
    w = '0;
    case (op)
      4'd0:    w = {6'b000000, s, t, d, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, s, t, d, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, s, t, d, 5'b00000, 6'b100100};
      4'd3:    w = {6'b000000, s, t, d, 5'b00000, 6'b100101};
      4'd4:    w = {6'b000000, s, t, d, 5'b00000, 6'b101010};
      4'd5:    w = {6'b100011, s, t, im};
      4'd6:    w = {6'b101011, s, t, im};
      4'd7:    w = {6'b000100, s, t, im};
      4'd8:    w = {6'b001000, s, t, im};
      default: w = '0;
    endcase
    return w;
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [31:0]   enc_p0;
  logic [31:0]   head;
  logic          accept;
  logic          push;
  logic          pop;

  // stage p0: combinational encode of the incoming request
  assign enc_p0 = encode(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.imm);
  assign accept = bus.in_valid && bus.in_ready;

`ifdef MIPS_ENC_ILLEGAL_TRAP_EN
  logic err_q;
  assign push = accept && (bus.op_sel <= 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 1'b0;
    else if (accept && (bus.op_sel > 4'd8)) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign push    = accept;
  assign bus.err = 1'b0;
`endif

  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // stage p1: storage is data-only, never reset; validity comes from level_q
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_p0;
  end

  assign head          = mem[rd_ptr];
  assign bus.level     = level_q;
  assign bus.in_ready  = (level_q != FULL_LVL);
  assign bus.out_valid = (level_q != '0);
  assign bus.instr     = bus.out_valid ? head : 32'h0;
  assign bus.opc       = bus.instr[31:26];
  assign bus.funct     = bus.instr[5:0];
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: queue-based reference model checked every cycle plus literal word checks.
module tb_mips_instr_encoder;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mips_instr_encoder_if #(.DEPTH(DEPTH)) bus();

  mips_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: opcode/funct tables and field placement by arithmetic.
  function automatic logic [31:0] model_word(input int op, input int s, input int t,
                                             input int d, input int im);
    int opc_tab [9]  = '{0, 0, 0, 0, 0, 35, 43, 4, 8};
    int fn_tab  [5]  = '{32, 34, 36, 37, 42};
    longint w;
    if (op > 8) return 32'h0;
    w = longint'(opc_tab[op]) * 67108864 + s * 2097152 + t * 65536;
    if (op <= 4) w = w + d * 2048 + fn_tab[op];
    else         w = w + im;
    return 32'(w);
  endfunction

  logic [31:0] q[$];
  logic        err_m;

  initial err_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      bit do_push, do_pop, legal;
      legal   = (bus.op_sel <= 4'd8);
      do_pop  = (q.size() != 0) && bus.out_ready;
`ifdef MIPS_ENC_ILLEGAL_TRAP_EN
      do_push = bus.in_valid && (q.size() < DEPTH) && legal;
      if (bus.in_valid && (q.size() < DEPTH) && !legal) err_m = 1'b1;
`else
      do_push = bus.in_valid && (q.size() < DEPTH);
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model_word(int'(bus.op_sel), int'(bus.rs), int'(bus.rt),
                                          int'(bus.rd), int'(bus.imm)));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] hw;
    hw = (q.size() != 0) ? q[0] : 32'h0;
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("in_ready",  32'(bus.in_ready),  32'(q.size() != DEPTH));
    check("level",     32'(bus.level),     32'(q.size()));
    check("instr",     bus.instr,          hw);
    check("opc",       32'(bus.opc),       32'(hw[31:26]));
    check("funct",     32'(bus.funct),     32'(hw[5:0]));
    check("err",       32'(bus.err),       32'(err_m));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] im);
    bus.in_valid = 1'b1;
    bus.op_sel   = op;
    bus.rs       = s;
    bus.rt       = t;
    bus.rd       = d;
    bus.imm      = im;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("drain_done", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_sel = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_level",     32'(bus.level),     32'h0);
    check("rst_instr",     bus.instr,          32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    check("rst_err",       32'(bus.err),       32'h0);

    // ADD r1, r2, r3
    bus.out_ready = 1'b1;
    req(4'd0, 5'd2, 5'd3, 5'd1, 16'h0);
    step();
    bus.in_valid = 1'b0;
    check("add_valid", 32'(bus.out_valid), 32'h1);
    check("add_instr", bus.instr,          32'h00430820);
    check("add_opc",   32'(bus.opc),       32'h0);
    check("add_funct", 32'(bus.funct),     32'h20);
    step();

    // LW / SW / BEQ back-to-back, then drained in order
    bus.out_ready = 1'b0;
    req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004); step();
    req(4'd6, 5'd29, 5'd8, 5'd0, 16'h0008); step();
    req(4'd7, 5'd1,  5'd2, 5'd0, 16'hFFFF); step();
    bus.in_valid = 1'b0;
    check("lw_instr", bus.instr, 32'h8FA80004);
    check("lw_opc",   32'(bus.opc), 32'h23);
    bus.out_ready = 1'b1;
    step();
    check("sw_instr", bus.instr, 32'hAFA80008);
    check("sw_opc",   32'(bus.opc), 32'h2B);
    step();
    check("beq_instr", bus.instr, 32'h1022FFFF);
    check("beq_opc",   32'(bus.opc), 32'h04);
    step();
    check("lsb_empty", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;

    // Fill to DEPTH, hold off a 5th push, then drain with the 5th sneaking in
    for (int i = 0; i < 4; i++) begin
      req(4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0);
      step();
    end
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_level",    32'(bus.level),    32'h4);
    req(4'd8, 5'd7, 5'd9, 5'd0, 16'h1234);
    step();
    step();
    check("held_level", 32'(bus.level), 32'h4);
    check("held_head",  bus.instr,      32'h00221820);
    bus.out_ready = 1'b1;
    acc = bus.in_ready;
    step();
    check("pop_only_level",  32'(bus.level),    32'h3);
    check("pop_only_ready",  32'(bus.in_ready), 32'h1);
    n = 0;
    while (!acc && n < 10) begin
      acc = bus.in_ready;
      step();
      n++;
    end
    check("fifth_accepted", 32'(acc), 32'h1);
    drain();

    // 10 push/pop pairs through the FIFO to wrap pointers
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req(4'(i % 9), 5'(i), 5'(31 - i), 5'(i * 3), 16'(16'hA000 + i));
      step();
    end
    drain();

    // Illegal op_sel
    req(4'hF, 5'd1, 5'd2, 5'd3, 16'h5555);
    step();
    bus.in_valid = 1'b0;
`ifdef MIPS_ENC_ILLEGAL_TRAP_EN
    check("ill_err",   32'(bus.err),   32'h1);
    check("ill_level", 32'(bus.level), 32'h0);
    req(4'd3, 5'd4, 5'd5, 5'd6, 16'h0);
    step();
    bus.in_valid = 1'b0;
    check("ill_sticky", 32'(bus.err), 32'h1);
`else
    check("ill_valid", 32'(bus.out_valid), 32'h1);
    check("ill_instr", bus.instr,          32'h0);
    check("ill_err",   32'(bus.err),       32'h0);
`endif
    drain();

    // Asynchronous reset with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      req(4'd1, 5'(i), 5'(i), 5'(i), 16'h0);
      step();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_level", 32'(bus.level), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 32'(bus.level),     32'h0);
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    check("arst_instr", bus.instr,          32'h0);
    check("arst_err",   32'(bus.err),       32'h0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req(4'd8, 5'd0, 5'd5, 5'd0, 16'h0007);
    step();
    bus.in_valid = 1'b0;
    check("addi_instr", bus.instr,    32'h20050007);
    check("addi_opc",   32'(bus.opc), 32'h08);
    drain();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the main control decoder: takes an abstract operation request (operation code plus register/immediate fields) and emits a 32-bit MIPS instruction word with separate opc/funct fields.
- Encoded words are buffered in a small FIFO, so the block can feed the control decoder or an instruction memory loader under a valid/ready handshake.
- Supported instructions: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDI.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op_sel  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI; 9-15 illegal.
- rs  input  5  source register.
- rt  input  5  second source register, or target register for I-type.
- rd  input  5  destination register for R-type; ignored for I-type.
- imm  input  16  immediate or branch offset; ignored for R-type.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- instr  output  32  encoded word at the FIFO head.
- opc  output  6  equals instr[31:26].
- funct  output  6  equals instr[5:0], raw for every type.
- level  output  $clog2(DEPTH)+1  current occupancy.
- err  output  1  sticky illegal-op flag.

Behaviour:
- Reset (async assert, sync release):
  - read/write pointers = 0, level = 0, out_valid = 0, err = 0.
  - instr/opc/funct = 0.
  - Reset asserted mid-operation flushes all entries immediately.
- Encoding:
  - R-type (op 0-4): opc 000000 | rs | rt | rd | shamt 00000 | funct.
  - funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: opc | rs | rt | imm, with opc LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - imm is passed unmodified; no sign handling.
- Push: on a clk edge with in_valid && in_ready, the encoded word is written at the write pointer, the write pointer increments modulo DEPTH, and level increments.
- in_ready = (level != DEPTH).
  - Registered-state function only; a same-cycle pop does not raise in_ready when full.
- Pop: on a clk edge with out_valid && out_ready, the read pointer increments modulo DEPTH and level decrements.
- out_valid = (level != 0).
- Head stability:
  - instr/opc/funct show the head entry and are held stable while out_valid && !out_ready.
  - These outputs are forced to 0 when out_valid = 0.
- Simultaneous push and pop (not full, not empty): level unchanged; both pointers advance.
- Latency: a request accepted at edge N into an empty FIFO produces out_valid = 1 with the word after edge N. There is no combinational in-to-out path.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH with no loss.
- Illegal op_sel: handled per the Optional Feature below.

Optional Feature:
- Macro: MIPS_ENC_ILLEGAL_TRAP_EN.
- Defined:
  - An accepted illegal op_sel is dropped: no push, level unchanged, in_ready unaffected.
  - err is set to 1 on that edge and stays 1 until reset.
- Undefined:
  - An illegal op_sel is encoded as NOP 0x00000000 and pushed normally.
  - err is tied to 0.

Test Plan:
- ADD request (rd=1, rs=2, rt=3), out_ready=1 -> out_valid one cycle later; instr=0x00430820, opc=000000, funct=100000.
- LW (rs=29, rt=8, imm=4), then SW (rs=29, rt=8, imm=8), then BEQ (rs=1, rt=2, imm=0xFFFF), pushed back-to-back -> popped in order as 0x8FA80004, 0xAFA80008, 0x1022FFFF, with opc 100011, 101011, 000100.
- DEPTH=4, out_ready=0, 5 valid pushes -> in_ready=0 after the 4th, level=4, 5th held off. Then out_ready=1 -> 4 words drained in order, the 5th accepted once in_ready=1, level returns to 0.
- Full FIFO with simultaneous in_valid and out_ready -> pop only that cycle; in_ready rises the next cycle. Run 10 push/pop pairs for pointer wrap -> no loss or reordering.
- op_sel=4'hF -> with the macro: err=1 sticky, level unchanged. Without the macro: 0x00000000 emitted.
- Assert rst_n low with 3 entries queued -> level=0, out_valid=0, instr=0 immediately. After release, an ADDI (rs=0, rt=5, imm=7) request encodes to 0x20050007.
